// File: rtl/video_bus_arbiter_pkg.sv
// video_arb_pkg: shared state encoding and bus geometry for the video bus arbiter
package video_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_OWN0, ST_OWN1} state_t;
  localparam int VIDEO_ADDR_W  = 21;
  localparam int VIDEO_DATA_W  = 32;
  localparam int FRAME_SEL_BIT = 20;
endpackage

// File: rtl/video_bus_arbiter_if.sv
// video_bus_arbiter_if: two write masters plus the shared video bus they contend for
interface video_bus_arbiter_if
  import video_arb_pkg::*;
#(
  parameter int ADDR_W = VIDEO_ADDR_W,
  parameter int DATA_W = VIDEO_DATA_W
);
  logic [1:0]        req;
  logic [1:0]        lock;
  logic [1:0]        wr;
  logic [ADDR_W-1:0] addr [2];
  logic [DATA_W-1:0] wr_data [2];
  logic [1:0]        gnt;
  logic [1:0]        ack;
  logic              video_cs;
  logic              video_wr;
  logic [ADDR_W-1:0] video_addr;
  logic [DATA_W-1:0] video_wr_data;
  logic              lock_timeout;
  modport slave (
    input  req, lock, wr, addr, wr_data,
    output gnt, ack, video_cs, video_wr, video_addr, video_wr_data, lock_timeout
  );
  modport master (
    output req, lock, wr, addr, wr_data,
    input  gnt, ack, video_cs, video_wr, video_addr, video_wr_data, lock_timeout
  );
endinterface

// File: rtl/video_bus_arbiter_out_stage.sv
// video_arb_out_stage: registered video bus drive with a per-master ack pulse per issued transfer
module video_arb_out_stage
  import video_arb_pkg::*;
#(
  parameter int ADDR_W = VIDEO_ADDR_W,
  parameter int DATA_W = VIDEO_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              owner_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              cs_o,
  output logic              wr_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        ack_o
);
  logic              cs_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        ack_q;
  // one staged transfer per load; reset drops anything staged so no cs/ack leaks out
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q   <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      ack_q  <= 2'b00;
    end else begin
      cs_q  <= load_i;
      wr_q  <= load_i & wr_i;
      ack_q <= {load_i & owner_i, load_i & ~owner_i};
      if (load_i) begin
        addr_q <= addr_i;
        data_q <= data_i;
      end
    end
  end
  assign cs_o   = cs_q;
  assign wr_o   = wr_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
  assign ack_o  = ack_q;
endmodule

// File: rtl/video_bus_arbiter.sv
// video_bus_arbiter: round-robin owner FSM with bus lock; VIDEO_ARB_TIMEOUT_EN adds forced lock release
module video_bus_arbiter
  import video_arb_pkg::*;
#(
  parameter int ADDR_W   = VIDEO_ADDR_W,
  parameter int DATA_W   = VIDEO_DATA_W,
  parameter int MAX_LOCK = 256
) (
  input  logic                clk,
  input  logic                reset,
  video_bus_arbiter_if.slave  bus
);
  state_t state_q;
  logic   rr_q;
  logic   own;
  logic   x;
  logic   req_x;
  logic   lock_x;
  logic   other_req;
  logic   load;
  logic   force_sw;
  if (MAX_LOCK < 2) begin : g_chk
    $error("MAX_LOCK must be at least 2");
  end
  assign own       = state_q != ST_IDLE;
  assign x         = state_q == ST_OWN1;
  assign req_x     = bus.req[x];
  assign lock_x    = bus.lock[x];
  assign other_req = bus.req[~x];
  assign load      = own & req_x;
`ifdef VIDEO_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_LOCK);
  logic [CW-1:0] cnt_q;
  assign force_sw = own & lock_x & other_req & (cnt_q == CW'(MAX_LOCK - 1));
  // counts consecutive locked cycles, saturating when nobody is waiting
  always_ff @(posedge clk) begin
    if (reset || !own || !lock_x || force_sw) cnt_q <= '0;
    else if (cnt_q != CW'(MAX_LOCK - 1)) cnt_q <= cnt_q + 1'b1;
  end
`else
  assign force_sw = 1'b0;
`endif
  assign bus.lock_timeout = force_sw;
  assign bus.gnt          = {state_q == ST_OWN1, state_q == ST_OWN0};
  // ownership FSM; leaving an owner points rr at the other master
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
    end else if (!own) begin
      if (|bus.req) state_q <= (bus.req[1] & (~bus.req[0] | rr_q)) ? ST_OWN1 : ST_OWN0;
    end else if (force_sw || (!lock_x && other_req)) begin
      state_q <= x ? ST_OWN0 : ST_OWN1;
      rr_q    <= ~x;
    end else if (!lock_x && !req_x) begin
      state_q <= ST_IDLE;
      rr_q    <= ~x;
    end
  end
  video_arb_out_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_out (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .owner_i (x),
    .wr_i    (bus.wr[x]),
    .addr_i  (bus.addr[x]),
    .data_i  (bus.wr_data[x]),
    .cs_o    (bus.video_cs),
    .wr_o    (bus.video_wr),
    .addr_o  (bus.video_addr),
    .data_o  (bus.video_wr_data),
    .ack_o   (bus.ack)
  );
endmodule

// File: tb/tb_video_bus_arbiter.sv
// tb_video_bus_arbiter: directed tests for grant order, transfer latency, lock bursts, reset and lock timeout
module tb_video_bus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  video_bus_arbiter_if #(.ADDR_W(21), .DATA_W(32)) bus ();
  video_bus_arbiter #(.ADDR_W(21), .DATA_W(32), .MAX_LOCK(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  function automatic logic [20:0] wa(input int m, input int k);
    return m != 0 ? 21'h10_0004 + 21'(4 * k) : 21'h00_0100 + 21'(4 * k);
  endfunction
  function automatic logic [31:0] wd(input int m, input int k);
    return m != 0 ? 32'hDEAD_BEEF + 32'(k) : 32'h1000_0000 + 32'(k);
  endfunction
  task automatic idle_inputs();
    bus.req = 2'b00;
    bus.lock = 2'b00;
    bus.wr = 2'b00;
    bus.addr[0] = '0;
    bus.addr[1] = '0;
    bus.wr_data[0] = '0;
    bus.wr_data[1] = '0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic stream(input int n0, input int n1, input int lk0, input logic wrv, input string exp, input string nm);
    int i0 = 0;
    int i1 = 0;
    int k = 0;
    int a0 = 0;
    int a1 = 0;
    int n = n0 + n1;
    bit started = 0;
    bit eo;
    int idx;
    logic [1:0] g = 2'b00;
    for (int c = 0; c < 200 && k < n; c++) begin
      if (g[0] && bus.req[0]) i0++;
      if (g[1] && bus.req[1]) i1++;
      bus.req = {1'(i1 < n1), 1'(i0 < n0)};
      bus.lock = {1'b0, 1'(i0 < lk0 - 1)};
      bus.wr = {wrv, wrv};
      bus.addr[0] = wa(0, i0);
      bus.addr[1] = wa(1, i1);
      bus.wr_data[0] = wd(0, i0);
      bus.wr_data[1] = wd(1, i1);
      g = bus.gnt;
      @(negedge clk);
      if (bus.video_cs === 1'b1) begin
        eo = exp[k] == "1";
        checks++;
        if (bus.ack !== (eo ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL %s owner xfer %0d: ack=%b expected %b", nm, k, bus.ack, eo ? 2'b10 : 2'b01);
        end
        idx = eo ? a1 : a0;
        checks++;
        if (bus.video_addr !== wa(int'(eo), idx) || bus.video_wr_data !== wd(int'(eo), idx) || bus.video_wr !== wrv) begin
          errors++;
          $display("FAIL %s data xfer %0d: addr=%h data=%h wr=%b expected addr=%h data=%h wr=%b",
                   nm, k, bus.video_addr, bus.video_wr_data, bus.video_wr, wa(int'(eo), idx), wd(int'(eo), idx), wrv);
        end
        if (eo) a1++;
        else a0++;
        k++;
        started = 1;
      end else begin
        checks++;
        if (started || bus.ack !== 2'b00) begin
          errors++;
          $display("FAIL %s gap at xfer %0d: cs=%b ack=%b expected cs=1 or idle with ack=00", nm, k, bus.video_cs, bus.ack);
        end
      end
    end
    checks++;
    if (k != n) begin
      errors++;
      $display("FAIL %s timeout: transfers=%0d expected %0d", nm, k, n);
    end
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.req = 2'b11;
    bus.wr = 2'b11;
    bus.addr[0] = wa(0, 0);
    bus.wr_data[0] = wd(0, 0);
    bus.addr[1] = wa(1, 0);
    bus.wr_data[1] = wd(1, 0);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({bus.gnt, bus.ack, bus.video_cs, bus.video_wr, bus.lock_timeout} !== 7'b0 ||
          bus.video_addr !== 21'h0 || bus.video_wr_data !== 32'h0) begin
        errors++;
        $display("FAIL reset outputs: gnt=%b ack=%b cs=%b wr=%b to=%b addr=%h data=%h expected all 0",
                 bus.gnt, bus.ack, bus.video_cs, bus.video_wr, bus.lock_timeout, bus.video_addr, bus.video_wr_data);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 2'b01 || bus.video_cs !== 1'b0) begin
      errors++;
      $display("FAIL reset first grant: gnt=%b cs=%b expected gnt=01 cs=0", bus.gnt, bus.video_cs);
    end
    @(negedge clk);
    checks++;
    if (bus.video_cs !== 1'b1 || bus.ack !== 2'b01 || bus.video_addr !== wa(0, 0) || bus.gnt !== 2'b10) begin
      errors++;
      $display("FAIL reset first xfer: cs=%b ack=%b addr=%h gnt=%b expected cs=1 ack=01 addr=%h gnt=10",
               bus.video_cs, bus.ack, bus.video_addr, bus.gnt, wa(0, 0));
    end
    idle_inputs();
    repeat (3) @(negedge clk);
  endtask
  task automatic test_single();
    do_reset();
    stream(0, 1, 0, 1'b1, "1", "single");
  endtask
  task automatic test_contention();
    do_reset();
    stream(4, 4, 0, 1'b1, "01010101", "contention");
  endtask
  task automatic test_lock_burst();
    do_reset();
    stream(8, 1, 8, 1'b1, "000000001", "lock_burst");
  endtask
  task automatic test_wr_low();
    do_reset();
    stream(1, 0, 0, 1'b0, "0", "wr_low");
  endtask
  task automatic test_reset_mid();
    do_reset();
    bus.req = 2'b01;
    bus.wr = 2'b01;
    bus.addr[0] = wa(0, 3);
    bus.wr_data[0] = wd(0, 3);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.video_cs !== 1'b1 || bus.ack !== 2'b01) begin
      errors++;
      $display("FAIL reset_mid staged: cs=%b ack=%b expected cs=1 ack=01", bus.video_cs, bus.ack);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.video_cs !== 1'b0 || bus.ack !== 2'b00 || bus.gnt !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid dropped: cs=%b ack=%b gnt=%b expected 0 00 00", bus.video_cs, bus.ack, bus.gnt);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.video_cs !== 1'b1 || bus.ack !== 2'b01 || bus.video_wr_data !== wd(0, 3)) begin
      errors++;
      $display("FAIL reset_mid resume: cs=%b ack=%b data=%h expected cs=1 ack=01 data=%h",
               bus.video_cs, bus.ack, bus.video_wr_data, wd(0, 3));
    end
    idle_inputs();
    repeat (3) @(negedge clk);
  endtask
  task automatic test_lock_timeout();
    int bad = 0;
    do_reset();
    bus.req = 2'b11;
    bus.lock = 2'b01;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 2'b01) begin
      errors++;
      $display("FAIL timeout owner: gnt=%b expected 01", bus.gnt);
    end
    bus.req = 2'b10;
`ifdef VIDEO_ARB_TIMEOUT_EN
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) @(negedge clk);
      if (bus.lock_timeout !== 1'(c == 16) || bus.gnt !== 2'b01) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL timeout pulse: %0d locked cycles with wrong to/gnt, expected pulse only at cycle 16", bad);
    end
    @(negedge clk);
    checks++;
    if (bus.gnt !== 2'b10 || bus.lock_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout switch: gnt=%b to=%b expected gnt=10 to=0", bus.gnt, bus.lock_timeout);
    end
`else
    repeat (1000) begin
      @(negedge clk);
      if (bus.gnt[1] !== 1'b0 || bus.lock_timeout !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL lock_hold: %0d cycles with m1 granted or timeout, expected 0", bad);
    end
`endif
    idle_inputs();
    repeat (3) @(negedge clk);
  endtask
  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_lock_burst();
    test_wr_low();
    test_reset_mid();
    test_lock_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
